// File: rtl/axi_xbar_pkg.sv
// Shared crossbar parameters and AXI burst encodings.
// Per-slave-port write controllers take their parameter defaults from here.
package axi_xbar_pkg;
  localparam int unsigned PORTS     = 3;
  localparam int unsigned IDX_W     = $clog2(PORTS);
  localparam int unsigned ID_W      = 4;
  localparam int unsigned ADDR_W    = 20;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ORD_DEPTH = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
endpackage

// File: rtl/wr_order_fifo.sv
// Write-order FIFO: holds the grant index of every accepted AW until its W burst ends.
// A push and a pop may occur in the same cycle when the FIFO is not full.
module wr_order_fifo #(
  parameter  int unsigned W     = 2,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == LVL_W'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + LVL_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/axi_write_mux_ctrl.sv
// Write-path controller for one crossbar slave port: round-robin AW arbitration with
// grant locking, W steering in AW grant order, and B routing by the ID's index bits.
module axi_write_mux_ctrl #(
  parameter  int unsigned PORTS     = axi_xbar_pkg::PORTS,
  parameter  int unsigned ADDR_W    = axi_xbar_pkg::ADDR_W,
  parameter  int unsigned ID_W      = axi_xbar_pkg::ID_W,
  parameter  int unsigned DATA_W    = axi_xbar_pkg::DATA_W,
  parameter  int unsigned ORD_DEPTH = axi_xbar_pkg::ORD_DEPTH,
  localparam int unsigned IDX_W     = $clog2(PORTS),
  localparam int unsigned STRB_W    = DATA_W / 8,
  localparam int unsigned LVL_W     = $clog2(ORD_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PORTS-1:0]          s_aw_valid,
  output logic [PORTS-1:0]          s_aw_ready,
  input  logic [PORTS*ADDR_W-1:0]   s_aw_addr,
  input  logic [PORTS*ID_W-1:0]     s_aw_id,
  input  logic [PORTS*8-1:0]        s_aw_len,
  input  logic [PORTS*3-1:0]        s_aw_size,
  input  logic [PORTS*2-1:0]        s_aw_burst,
  input  logic [PORTS-1:0]          s_w_valid,
  output logic [PORTS-1:0]          s_w_ready,
  input  logic [PORTS*DATA_W-1:0]   s_w_data,
  input  logic [PORTS*STRB_W-1:0]   s_w_strb,
  input  logic [PORTS-1:0]          s_w_last,
  output logic [PORTS-1:0]          s_b_valid,
  input  logic [PORTS-1:0]          s_b_ready,
  output logic [ID_W-1:0]           s_b_id,
  output logic [1:0]                s_b_resp,
  output logic                      m_aw_valid,
  input  logic                      m_aw_ready,
  output logic [ADDR_W-1:0]         m_aw_addr,
  output logic [IDX_W+ID_W-1:0]     m_aw_id,
  output logic [7:0]                m_aw_len,
  output logic [2:0]                m_aw_size,
  output logic [1:0]                m_aw_burst,
  output logic                      m_w_valid,
  input  logic                      m_w_ready,
  output logic [DATA_W-1:0]         m_w_data,
  output logic [STRB_W-1:0]         m_w_strb,
  output logic                      m_w_last,
  input  logic                      m_b_valid,
  output logic                      m_b_ready,
  input  logic [IDX_W+ID_W-1:0]     m_b_id,
  input  logic [1:0]                m_b_resp,
  output logic [LVL_W-1:0]          ord_level
);
  localparam logic [2*PORTS-1:0] DW_ONE = {{(2*PORTS-1){1'b0}}, 1'b1};

  logic             locked_q, locked_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic [2*PORTS-1:0] dreq, dmask, dsel;
  logic [IDX_W-1:0]   rr_idx, grant, head, b_idx;
  logic               aw_req, aw_fire, fifo_full, fifo_empty, push, pop;
  logic               w_sel_valid, b_hit, b_sel_ready;

  // Requests are duplicated so the lowest set bit above last_q wraps around naturally.
  always_comb begin
    dmask = '0;
    for (int unsigned j = 0; j < 2 * PORTS; j++) begin
      dmask[j] = (j > 32'(last_q));
    end
    dreq   = {s_aw_valid, s_aw_valid} & dmask;
    dsel   = dreq & ~(dreq - DW_ONE);
    rr_idx = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (dsel[i] || dsel[i+PORTS]) rr_idx = IDX_W'(i);
    end
  end

  always_comb begin
    grant      = locked_q ? lock_idx_q : rr_idx;
    aw_req     = locked_q ? 1'b0 : |s_aw_valid;
    m_aw_addr  = '0;
    m_aw_id    = '0;
    m_aw_len   = '0;
    m_aw_size  = '0;
    m_aw_burst = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (grant == IDX_W'(i)) begin
        if (locked_q) aw_req = s_aw_valid[i];
        m_aw_addr  = s_aw_addr[i*ADDR_W +: ADDR_W];
        m_aw_id    = {grant, s_aw_id[i*ID_W +: ID_W]};
        m_aw_len   = s_aw_len[i*8 +: 8];
        m_aw_size  = s_aw_size[i*3 +: 3];
        m_aw_burst = s_aw_burst[i*2 +: 2];
      end
    end
    m_aw_valid = !reset && !fifo_full && aw_req;
    aw_fire    = m_aw_valid && m_aw_ready;
    s_aw_ready = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      s_aw_ready[i] = aw_fire && (grant == IDX_W'(i));
    end
    push = aw_fire;
  end

  // The lock holds once a valid is offered; the rotation pointer moves only on an accept.
  always_comb begin
    locked_d   = locked_q ? !aw_fire : (m_aw_valid && !m_aw_ready);
    lock_idx_d = locked_q ? lock_idx_q : grant;
    last_d     = aw_fire ? grant : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
      last_q     <= IDX_W'(PORTS - 1);
    end else begin
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
      last_q     <= last_d;
    end
  end

  wr_order_fifo #(
    .W     (IDX_W),
    .DEPTH (ORD_DEPTH)
  ) u_ord (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (grant),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (ord_level)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    m_w_data    = '0;
    m_w_strb    = '0;
    m_w_last    = 1'b0;
    s_w_ready   = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (head == IDX_W'(i)) begin
        w_sel_valid  = s_w_valid[i];
        m_w_data     = s_w_data[i*DATA_W +: DATA_W];
        m_w_strb     = s_w_strb[i*STRB_W +: STRB_W];
        m_w_last     = s_w_last[i];
        s_w_ready[i] = !reset && !fifo_empty && m_w_ready;
      end
    end
    m_w_valid = !reset && !fifo_empty && w_sel_valid;
    pop       = m_w_valid && m_w_ready && m_w_last;
  end

  // Responses whose index bits name no master are accepted and discarded.
  always_comb begin
    b_idx       = m_b_id[IDX_W+ID_W-1:ID_W];
    b_hit       = 1'b0;
    b_sel_ready = 1'b0;
    s_b_valid   = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (b_idx == IDX_W'(i)) begin
        b_hit        = 1'b1;
        b_sel_ready  = s_b_ready[i];
        s_b_valid[i] = !reset && m_b_valid;
      end
    end
    m_b_ready = !reset && (b_hit ? b_sel_ready : 1'b1);
    s_b_id    = m_b_id[ID_W-1:0];
    s_b_resp  = m_b_resp;
  end
endmodule

// File: tb/tb_axi_write_mux_ctrl.sv
// Bench for axi_write_mux_ctrl: directed scenarios with literal expectations, then
// randomized masters and slave, all checked every cycle against a queue-based model.
module tb_axi_write_mux_ctrl;
  localparam int P = 3, AW = 20, IW = 4, DW = 32, SW = DW / 8, DEPTH = 4, IX = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic [P-1:0] s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_w_last;
  logic [P-1:0] s_b_valid, s_b_ready;
  logic [P*AW-1:0] s_aw_addr;
  logic [P*IW-1:0] s_aw_id;
  logic [P*8-1:0]  s_aw_len;
  logic [P*3-1:0]  s_aw_size;
  logic [P*2-1:0]  s_aw_burst;
  logic [P*DW-1:0] s_w_data;
  logic [P*SW-1:0] s_w_strb;
  logic [IW-1:0]   s_b_id;
  logic [1:0]      s_b_resp, m_b_resp, m_aw_burst;
  logic m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_w_last, m_b_valid, m_b_ready;
  logic [AW-1:0]    m_aw_addr;
  logic [IX+IW-1:0] m_aw_id, m_b_id;
  logic [7:0]       m_aw_len;
  logic [2:0]       m_aw_size;
  logic [DW-1:0]    m_w_data;
  logic [SW-1:0]    m_w_strb;
  logic [2:0]       ord_level;

  axi_write_mux_ctrl #(
    .PORTS(P), .ADDR_W(AW), .ID_W(IW), .DATA_W(DW), .ORD_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr),
    .s_aw_id(s_aw_id), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
    .s_w_strb(s_w_strb), .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
    .m_aw_id(m_aw_id), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
    .m_w_strb(m_w_strb), .m_w_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
    .ord_level(ord_level)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending grant order, last granted master, locked master (-1 = none).
  int mq[$];
  int m_last = P - 1;
  int m_lock = -1;

  always @(negedge clk) begin
    int g, h, bi;
    bit v, wv;
    logic [63:0] e_sar, e_swr, e_sbv, e_aid;
    logic e_mbr;
    v = 0; g = 0;
    if (!reset && mq.size() < DEPTH) begin
      if (m_lock >= 0) begin
        g = m_lock; v = s_aw_valid[g];
      end else begin
        for (int k = 1; k <= P; k++) begin
          if (!v && s_aw_valid[(m_last + k) % P]) begin
            v = 1; g = (m_last + k) % P;
          end
        end
      end
    end
    chk("ord_level", 64'(ord_level), 64'(mq.size()));
    chk("m_aw_valid", 64'(m_aw_valid), 64'(v));
    e_sar = (v && m_aw_ready) ? (64'd1 << g) : 64'd0;
    chk("s_aw_ready", 64'(s_aw_ready), e_sar);
    if (v) begin
      e_aid = (64'(g) << IW) | 64'(s_aw_id[g*IW +: IW]);
      chk("m_aw_id", 64'(m_aw_id), e_aid);
      chk("m_aw_addr", 64'(m_aw_addr), 64'(s_aw_addr[g*AW +: AW]));
      chk("m_aw_len", 64'(m_aw_len), 64'(s_aw_len[g*8 +: 8]));
      chk("m_aw_size", 64'(m_aw_size), 64'(s_aw_size[g*3 +: 3]));
      chk("m_aw_burst", 64'(m_aw_burst), 64'(s_aw_burst[g*2 +: 2]));
    end
    h  = (mq.size() > 0) ? mq[0] : 0;
    wv = !reset && mq.size() > 0 && s_w_valid[h];
    chk("m_w_valid", 64'(m_w_valid), 64'(wv));
    e_swr = (!reset && mq.size() > 0 && m_w_ready) ? (64'd1 << h) : 64'd0;
    chk("s_w_ready", 64'(s_w_ready), e_swr);
    if (wv) begin
      chk("m_w_data", 64'(m_w_data), 64'(s_w_data[h*DW +: DW]));
      chk("m_w_strb", 64'(m_w_strb), 64'(s_w_strb[h*SW +: SW]));
      chk("m_w_last", 64'(m_w_last), 64'(s_w_last[h]));
    end
    bi = int'(m_b_id) >> IW;
    if (reset) begin
      e_sbv = 0; e_mbr = 0;
    end else if (bi < P) begin
      e_sbv = m_b_valid ? (64'd1 << bi) : 64'd0; e_mbr = s_b_ready[bi];
    end else begin
      e_sbv = 0; e_mbr = 1;
    end
    chk("s_b_valid", 64'(s_b_valid), e_sbv);
    chk("m_b_ready", 64'(m_b_ready), 64'(e_mbr));
    chk("s_b_id", 64'(s_b_id), 64'(m_b_id[IW-1:0]));
    chk("s_b_resp", 64'(s_b_resp), 64'(m_b_resp));
    if (reset) begin
      mq.delete(); m_last = P - 1; m_lock = -1;
    end else begin
      if (wv && m_w_ready && s_w_last[h]) void'(mq.pop_front());
      if (v && m_aw_ready) begin
        mq.push_back(g); m_last = g; m_lock = -1;
      end else if (v) begin
        m_lock = g;
      end
    end
  end

  // Random master state
  bit aw_pend[P];
  bit w_on[P];
  int beat[P];
  int wq[P][$];
  logic [AW-1:0] r_addr[P];
  logic [IW-1:0] r_id[P];
  logic [7:0]    r_len[P];
  logic [2:0]    r_size[P];
  logic [1:0]    r_burst[P];
  logic [DW-1:0] r_data[P];
  logic [SW-1:0] r_strb[P];

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_masters();
    for (int i = 0; i < P; i++) begin
      aw_pend[i] = 0; w_on[i] = 0; beat[i] = 0; wq[i].delete();
      r_addr[i] = '0; r_id[i] = '0; r_len[i] = '0; r_size[i] = '0; r_burst[i] = '0;
      r_data[i] = '0; r_strb[i] = '0;
    end
  endtask

  task automatic pack_masters();
    for (int i = 0; i < P; i++) begin
      s_aw_valid[i] = aw_pend[i];
      s_aw_addr[i*AW +: AW] = r_addr[i];
      s_aw_id[i*IW +: IW]   = r_id[i];
      s_aw_len[i*8 +: 8]    = r_len[i];
      s_aw_size[i*3 +: 3]   = r_size[i];
      s_aw_burst[i*2 +: 2]  = r_burst[i];
      s_w_valid[i] = w_on[i];
      s_w_data[i*DW +: DW]  = r_data[i];
      s_w_strb[i*SW +: SW]  = r_strb[i];
      s_w_last[i] = w_on[i] && (beat[i] == wq[i][0]);
    end
  endtask

  initial begin
    int rst_cnt;
    s_aw_valid = '1; s_aw_addr = '0; s_aw_id = {4'h3, 4'h2, 4'h1}; s_aw_len = '0;
    s_aw_size = '0; s_aw_burst = '0; s_w_valid = '1; s_w_data = '0; s_w_strb = '0;
    s_w_last = '0; s_b_ready = '1; m_aw_ready = 1; m_w_ready = 1; m_b_valid = 1;
    m_b_id = 6'h03; m_b_resp = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_aw_valid", 64'(m_aw_valid), 0);
    chk("rst_s_aw_ready", 64'(s_aw_ready), 0);
    chk("rst_m_w_valid", 64'(m_w_valid), 0);
    chk("rst_s_w_ready", 64'(s_w_ready), 0);
    chk("rst_m_b_ready", 64'(m_b_ready), 0);
    chk("rst_s_b_valid", 64'(s_b_valid), 0);
    chk("rst_ord_level", 64'(ord_level), 0);

    cyc(); reset = 0; s_w_valid = '0; m_b_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_grant", 64'(s_aw_ready), 64'(1 << (k % 3)));
      chk("rr_id_idx", 64'(m_aw_id[IX+IW-1:IW]), 64'(k % 3));
      cyc();
    end
    @(negedge clk);
    chk("full_level", 64'(ord_level), 4);
    chk("full_no_aw", 64'(m_aw_valid), 0);

    cyc(); m_b_valid = 1; m_b_id = 6'h1A; s_b_ready = 3'b010;
    @(negedge clk);
    chk("b_route_valid", 64'(s_b_valid), 64'b010);
    chk("b_route_id", 64'(s_b_id), 64'hA);
    chk("b_route_ready", 64'(m_b_ready), 1);
    cyc(); s_b_ready = 3'b101;
    @(negedge clk);
    chk("b_route_stall", 64'(m_b_ready), 0);
    cyc(); m_b_id = 6'h35; s_b_ready = 3'b000;
    @(negedge clk);
    chk("b_drop_ready", 64'(m_b_ready), 1);
    chk("b_drop_valid", 64'(s_b_valid), 0);

    cyc(); m_b_valid = 0; s_w_valid = 3'b001; s_w_last = 3'b001;
    @(negedge clk);
    chk("pop_w_ready", 64'(s_w_ready), 64'b001);
    chk("pop_aw_blocked", 64'(s_aw_ready), 0);
    cyc(); s_w_valid = '0;
    @(negedge clk);
    chk("after_pop_level", 64'(ord_level), 3);
    chk("after_pop_grant", 64'(s_aw_ready), 64'b010);

    cyc(); s_aw_valid = '0; reset = 1;
    cyc(); cyc(); reset = 0; s_aw_valid = 3'b010; m_aw_ready = 0;
    s_aw_addr[AW +: AW] = 20'h12345;
    @(negedge clk);
    chk("lock_wait_ready", 64'(s_aw_ready), 0);
    chk("lock_wait_valid", 64'(m_aw_valid), 1);
    cyc(); s_aw_valid = 3'b011;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lock_hold_idx", 64'(m_aw_id[IX+IW-1:IW]), 1);
      chk("lock_hold_addr", 64'(m_aw_addr), 64'h12345);
      cyc();
    end
    m_aw_ready = 1;
    @(negedge clk);
    chk("lock_fire", 64'(s_aw_ready), 64'b010);
    cyc(); s_aw_valid = 3'b001;
    @(negedge clk);
    chk("lock_next", 64'(s_aw_ready), 64'b001);
    cyc(); s_aw_valid = '0; reset = 1;

    clear_masters();
    rst_cnt = 2;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      for (int i = 0; i < P; i++) begin
        if (s_w_valid[i] && s_w_ready[i]) begin
          if (beat[i] == wq[i][0]) begin
            void'(wq[i].pop_front()); beat[i] = 0;
          end else begin
            beat[i]++;
          end
          w_on[i] = 0;
        end
        if (s_aw_valid[i] && s_aw_ready[i]) begin
          wq[i].push_back(int'(r_len[i])); aw_pend[i] = 0;
        end
      end
      cyc();
      if (rst_cnt == 0 && $urandom_range(0, 249) == 0) rst_cnt = $urandom_range(1, 2);
      reset = (rst_cnt > 0);
      if (rst_cnt > 0) begin
        rst_cnt--;
        clear_masters();
      end else begin
        for (int i = 0; i < P; i++) begin
          if (!aw_pend[i] && wq[i].size() < 4 && $urandom_range(0, 2) == 0) begin
            aw_pend[i] = 1;
            r_addr[i] = AW'($urandom); r_id[i] = IW'($urandom);
            r_len[i] = 8'($urandom_range(0, 3)); r_size[i] = 3'($urandom);
            r_burst[i] = 2'($urandom_range(0, 2));
          end
          if (wq[i].size() > 0 && !w_on[i] && $urandom_range(0, 3) != 0) begin
            w_on[i] = 1; r_data[i] = $urandom; r_strb[i] = SW'($urandom);
          end
        end
      end
      pack_masters();
      m_aw_ready = ($urandom_range(0, 3) != 0);
      m_w_ready  = ($urandom_range(0, 3) != 0);
      m_b_valid  = 1'($urandom);
      m_b_id     = 6'($urandom_range(0, 63));
      m_b_resp   = 2'($urandom);
      s_b_ready  = 3'($urandom);
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
